// File: rtl/cam_capture_ctrl_if.sv
// Camera-to-frame-buffer capture bus.
// Groups the camera sync/byte inputs and the downsampler / frame-buffer
// side outputs of cam_capture_ctrl.
//   slave  : the capture controller (samples camera, drives pixel/write side)
//   master : the surrounding system (drives camera side, consumes writes)
interface cam_capture_ctrl_if #(
  parameter int ADDR_W = 15
) ();
  logic              capture_en;
  logic              vsync;
  logic              href;
  logic [7:0]        cam_data;
  logic [15:0]       pixel_word;
  logic              data_val;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              frame_done;
  logic              short_frame;
  logic              byte_err;

  modport master (
    output capture_en, vsync, href, cam_data,
    input  pixel_word, data_val, wr_en, wr_addr,
           frame_done, short_frame, byte_err
  );

  modport slave (
    input  capture_en, vsync, href, cam_data,
    output pixel_word, data_val, wr_en, wr_addr,
           frame_done, short_frame, byte_err
  );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera capture sequencer.
// Watches VSYNC/HREF, pairs the byte-serial RGB565 stream into 16-bit
// words, strobes data_val into the RGB332 downsampler and issues the
// frame-buffer write (wr_en/wr_addr) one cycle later, aligned with the
// downsampler's registered output. Reports frame completion, short frames
// and unpaired bytes.
// Ports:
//   clk    camera pixel clock, all logic on posedge
//   rst_n  asynchronous active-low reset
//   bus    cam_capture_ctrl_if.slave: capture_en, vsync, href, cam_data in;
//          pixel_word, data_val, wr_en, wr_addr, frame_done, short_frame,
//          byte_err out
//
// state     | meaning
// ----------+-------------------------------------------------------------
// SYNC_WAIT | waiting for a VSYNC pulse; never captures a partial frame
// VS_ACTIVE | inside vertical blanking; frame starts on VSYNC fall
// LINE_WAIT | between lines, waiting for HREF
// BYTE_LO   | high byte latched, next byte completes the pixel
// BYTE_HI   | pixel complete, next byte is a new high byte
module cam_capture_ctrl #(
  parameter int H_PIX   = 176,
  parameter int V_LINES = 144,
  parameter int ADDR_W  = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  cam_capture_ctrl_if.slave  bus
);

  localparam int COL_W = $clog2(H_PIX + 1);
  localparam int ROW_W = $clog2(V_LINES + 1);

  localparam logic [COL_W-1:0]  H_LIM    = COL_W'(H_PIX);
  localparam logic [ROW_W-1:0]  V_LIM    = ROW_W'(V_LINES);
  localparam logic [ADDR_W-1:0] H_STEP   = ADDR_W'(H_PIX);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);

  typedef enum logic [2:0] {
    SYNC_WAIT,
    VS_ACTIVE,
    LINE_WAIT,
    BYTE_LO,
    BYTE_HI
  } state_t;

  state_t            state_q;
  logic [7:0]        hi_byte_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] dv_addr_q;
  logic [15:0]       pixel_word_q;
  logic              data_val_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic              frame_done_q;
  logic              short_frame_q;
  logic              byte_err_q;

  logic in_line;
  logic frame_end;
  logic line_end;
  logic store_pix;

  // VSYNC is low for the whole active frame, so seeing it high in any
  // active state is the rising edge that ends the frame.
  assign in_line   = (state_q == BYTE_LO) || (state_q == BYTE_HI);
  assign frame_end = bus.vsync && (in_line || (state_q == LINE_WAIT));
  assign line_end  = !bus.vsync && !bus.href && in_line;
  assign store_pix = (col_q < H_LIM) && (row_q < V_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC_WAIT;
      hi_byte_q     <= '0;
      col_q         <= '0;
      row_q         <= '0;
      base_q        <= '0;
      addr_q        <= '0;
      dv_addr_q     <= '0;
      pixel_word_q  <= '0;
      data_val_q    <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      frame_done_q  <= 1'b0;
      short_frame_q <= 1'b0;
      byte_err_q    <= 1'b0;
    end else begin
      data_val_q   <= 1'b0;
      frame_done_q <= 1'b0;
      // Downsampler output lands one cycle after data_val; follow it.
      wr_en_q      <= data_val_q;
      wr_addr_q    <= dv_addr_q;

      case (state_q)
        SYNC_WAIT: begin
          if (bus.vsync) state_q <= VS_ACTIVE;
        end

        VS_ACTIVE: begin
          if (!bus.vsync) begin
            if (bus.capture_en) begin
              state_q       <= LINE_WAIT;
              row_q         <= '0;
              col_q         <= '0;
              base_q        <= '0;
              addr_q        <= '0;
              short_frame_q <= 1'b0;
              byte_err_q    <= 1'b0;
            end else begin
              state_q <= SYNC_WAIT;
            end
          end
        end

        LINE_WAIT: begin
          if (bus.vsync) begin
            state_q <= VS_ACTIVE;
          end else if (bus.href) begin
            hi_byte_q <= bus.cam_data;
            state_q   <= BYTE_LO;
          end
        end

        BYTE_LO: begin
          if (bus.vsync) begin
            state_q    <= VS_ACTIVE;
            byte_err_q <= 1'b1;
          end else if (bus.href) begin
            pixel_word_q <= {hi_byte_q, bus.cam_data};
            state_q      <= BYTE_HI;
            if (store_pix) begin
              data_val_q <= 1'b1;
              dv_addr_q  <= addr_q;
              addr_q     <= addr_q + ADDR_ONE;
              col_q      <= col_q + COL_ONE;
            end
          end else begin
            // Odd byte count: the pending high byte is dropped.
            byte_err_q <= 1'b1;
            state_q    <= LINE_WAIT;
          end
        end

        BYTE_HI: begin
          if (bus.vsync) begin
            state_q <= VS_ACTIVE;
          end else if (bus.href) begin
            hi_byte_q <= bus.cam_data;
            state_q   <= BYTE_LO;
          end else begin
            state_q <= LINE_WAIT;
          end
        end

        default: state_q <= SYNC_WAIT;
      endcase

      // Every line advances the base by a full line, so a short line
      // leaves a gap and each row always starts at row*H_PIX.
      if (line_end && (row_q < V_LIM)) begin
        row_q  <= row_q + ROW_ONE;
        base_q <= base_q + H_STEP;
        addr_q <= base_q + H_STEP;
        col_q  <= '0;
      end

      if (frame_end) begin
        frame_done_q <= 1'b1;
        if (row_q < V_LIM) short_frame_q <= 1'b1;
      end
    end
  end

  assign bus.pixel_word  = pixel_word_q;
  assign bus.data_val    = data_val_q;
  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.short_frame = short_frame_q;
  assign bus.byte_err    = byte_err_q;

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Sequences the camera pixel path into the frame buffer. Watches the camera frame and line syncs, and pairs the byte-serial RGB565 bus into 16-bit words. Emits the one-cycle data_val strobe that loads the RGB332 downsampler. Generates the frame-buffer write address and write enable, timed to the downsampler's registered output, and reports frame completion and framing errors.

Parameters:
H_PIX, 176, pixels stored per line
V_LINES, 144, lines stored per frame
ADDR_W, 15, frame-buffer address width (must satisfy H_PIX*V_LINES <= 2^ADDR_W)

Ports:
clk  in  1  camera pixel clock domain; all logic on posedge
rst_n  in  1  asynchronous active-low reset
capture_en  in  1  arm capture; sampled only at frame boundaries
vsync  in  1  camera VSYNC, high during vertical blanking
href  in  1  camera HREF, high while line bytes are valid
cam_data  in  8  camera byte bus
pixel_word  out  16  assembled RGB565 pixel; drives the downsampler pixel input
data_val  out  1  one-cycle strobe; pixel_word valid, drives the downsampler data_val
wr_en  out  1  frame-buffer write enable, data_val delayed one cycle
wr_addr  out  ADDR_W  frame-buffer write address, valid with wr_en
frame_done  out  1  one-cycle pulse at end of each captured frame
short_frame  out  1  sticky flag: a frame ended with fewer than V_LINES lines; cleared on the next frame start
byte_err  out  1  sticky flag: href fell with an unpaired byte; cleared on the next frame start

Behaviour:
- Reset (async, rst_n=0):
  - State = SYNC_WAIT.
  - All outputs = 0.
  - Column, row, address and hi_byte registers = 0.
- All inputs are treated as synchronous to clk; no synchronisers.
- States:
  - SYNC_WAIT:
    - Stay until vsync=1, then go to VS_ACTIVE.
    - Ensures a partial frame after reset or enable is never captured.
  - VS_ACTIVE:
    - On vsync 1->0 with capture_en=1: go to LINE_WAIT; clear row, col, address, short_frame and byte_err.
    - On vsync 1->0 with capture_en=0: go to SYNC_WAIT.
  - LINE_WAIT:
    - href=1: latch cam_data into hi_byte and go to BYTE_LO. The first byte of a line is the high byte.
    - vsync=1: frame end, see below.
  - BYTE_LO:
    - href=1: pixel_word <= {hi_byte, cam_data}; go to BYTE_HI.
    - data_val=1 next cycle only if col < H_PIX and row < V_LINES. Then col increments.
  - BYTE_HI:
    - href=1: latch hi_byte and go to BYTE_LO.
    - href=0: line end, go to LINE_WAIT.
  - Unpaired byte: href=0 while in BYTE_LO means an odd byte count. Drop the byte, set byte_err, then run the line-end action.
- Line-end action:
  - If row < V_LINES: row++, base address += H_PIX, running address = new base, col = 0.
  - Short lines therefore leave a gap; the next line always starts at row*H_PIX.
  - Bytes beyond H_PIX pixels are consumed and paired but not written.
- Frame end: vsync 0->1 in LINE_WAIT, BYTE_HI or BYTE_LO.
  - frame_done pulses for one cycle.
  - short_frame is set if row < V_LINES.
  - Go to VS_ACTIVE; the loop continues while capture_en=1.
  - vsync rising mid-line abandons the line with no further writes. byte_err is set if a high byte was pending.
- Timing:
  - data_val has a latency of 1 cycle from the low-byte edge.
  - The downsampler registers on data_val, so its output is valid one cycle later. wr_en is data_val delayed 1 cycle, and wr_addr is the pixel's address delayed 1 cycle.
  - The address of the k-th stored pixel in row r is r*H_PIX + k. This is computed by increment only; no multiplier.
- Lines beyond V_LINES are ignored, with no writes and no address advance.
- capture_en falling mid-frame has no effect until the next VS_ACTIVE exit.
- Reset mid-frame aborts immediately with no frame_done.
- Back-to-back pixels: data_val may assert every second clk; wr_en likewise.

Test Plan:
- Reset, then 2 frames of 144 lines x 352 bytes (byte = index mod 256), capture_en=1:
  - First vsync pulse only arms; frame 1 gives 25344 wr_en pulses with addresses 0..25343 in order.
  - Pixel 0 = 0x0001.
  - frame_done fires once per frame; short_frame=0, byte_err=0.
- Latency check: bytes 0xF8, 0x1F at line start:
  - data_val fires 1 cycle after the 0x1F edge with pixel_word=0xF81F.
  - wr_en fires exactly 1 cycle after data_val.
- Line of 400 bytes (200 pixels), then a line of 100 bytes:
  - First line writes 176 pixels at addresses 0..175.
  - Second line writes 50 pixels at 176..225.
  - Third line starts at 352.
- Line with 351 bytes: byte_err=1, 175 writes, next line at 176; byte_err clears at the next frame start.
- vsync rises after 100 lines: frame_done pulses, short_frame=1, no writes beyond address 17599.
- capture_en=0 at a frame boundary yields no writes. rst_n low mid-line clears all outputs asynchronously, and capture resumes only after a full vsync pulse.
